// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller <-> pipeline signal bundle
//
// Ports (master = controller side):
//   hazard sources in : if_busy, ls_busy, ex_busy, ex_is_load, ex_rd, id_rs1/2,
//                       id_rs1/2_used, ex_br_taken, ex_br_target, ex_mret, mepc,
//                       ls_trap_req, trap_vec
//   controls out      : stall_n_if/id/ex/ls, flush_id/ex/ls, in_trap_id, out_trap_id,
//                       redirect_valid, redirect_pc, trap_ack, stall_cnt, redirect_cnt
interface pipe_hazard_ctrl_if #(
  parameter int XLEN   = 64,
  parameter int RIDX_W = 5
);
  logic              if_busy;
  logic              ls_busy;
  logic              ex_busy;
  logic              ex_is_load;
  logic [RIDX_W-1:0] ex_rd;
  logic [RIDX_W-1:0] id_rs1;
  logic [RIDX_W-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic              ex_br_taken;
  logic [XLEN-1:0]   ex_br_target;
  logic              ex_mret;
  logic [XLEN-1:0]   mepc;
  logic              ls_trap_req;
  logic [XLEN-1:0]   trap_vec;

  logic              stall_n_if;
  logic              stall_n_id;
  logic              stall_n_ex;
  logic              stall_n_ls;
  logic              flush_id;
  logic              flush_ex;
  logic              flush_ls;
  logic              in_trap_id;
  logic              out_trap_id;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              trap_ack;
  logic [31:0]       stall_cnt;
  logic [31:0]       redirect_cnt;

  modport master (
    input  if_busy, ls_busy, ex_busy, ex_is_load, ex_rd, id_rs1, id_rs2,
           id_rs1_used, id_rs2_used, ex_br_taken, ex_br_target, ex_mret, mepc,
           ls_trap_req, trap_vec,
    output stall_n_if, stall_n_id, stall_n_ex, stall_n_ls, flush_id, flush_ex,
           flush_ls, in_trap_id, out_trap_id, redirect_valid, redirect_pc,
           trap_ack, stall_cnt, redirect_cnt
  );

  modport slave (
    output if_busy, ls_busy, ex_busy, ex_is_load, ex_rd, id_rs1, id_rs2,
           id_rs1_used, id_rs2_used, ex_br_taken, ex_br_target, ex_mret, mepc,
           ls_trap_req, trap_vec,
    input  stall_n_if, stall_n_id, stall_n_ex, stall_n_ls, flush_id, flush_ex,
           flush_ls, in_trap_id, out_trap_id, redirect_valid, redirect_pc,
           trap_ack, stall_cnt, redirect_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - five-stage pipeline stall/flush/redirect and trap sequencer
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : pipe_hazard_ctrl_if.master (hazard sources in, stage controls out)
// Optional: PIPE_HAZARD_CTRL_PERF_EN builds the stall/redirect perf counters;
//           otherwise stall_cnt/redirect_cnt read 0.
module pipe_hazard_ctrl #(
  parameter int XLEN   = 64,
  parameter int RIDX_W = 5
) (
  input logic             clk,
  input logic             rst,
  pipe_hazard_ctrl_if.master bus
);

  typedef enum logic [1:0] {RUN, DRAIN, ENTER, EXIT} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   vec_q, vec_d;
  logic [XLEN-1:0]   mepc_q, mepc_d;

  logic              stall_n_if, stall_n_id, stall_n_ex, stall_n_ls;
  logic              flush_id, flush_ex, flush_ls;
  logic              in_trap_id, out_trap_id, trap_ack;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              load_use;

  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = bus.ex_is_load && (bus.ex_rd != {RIDX_W{1'b0}}) &&
                    ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));

  always_comb begin
    state_d        = state_q;
    vec_d          = vec_q;
    mepc_d         = mepc_q;
    stall_n_if     = 1'b1;
    stall_n_id     = 1'b1;
    stall_n_ex     = 1'b1;
    stall_n_ls     = 1'b1;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    flush_ls       = 1'b0;
    in_trap_id     = 1'b0;
    out_trap_id    = 1'b0;
    trap_ack       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Outputs keep their idle values while rst is held, whatever the state.
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (bus.ls_trap_req) begin
            // Freeze everything; the trapping instruction must finish its memory access first.
            stall_n_if = 1'b0;
            stall_n_id = 1'b0;
            stall_n_ex = 1'b0;
            stall_n_ls = 1'b0;
            vec_d      = bus.trap_vec;
            state_d    = bus.ls_busy ? DRAIN : ENTER;
          end else if (bus.ls_busy) begin
            stall_n_if = 1'b0;
            stall_n_id = 1'b0;
            stall_n_ex = 1'b0;
            stall_n_ls = 1'b0;
          end else if (bus.ex_busy) begin
            // LS keeps draining; feed it bubbles while EX is occupied.
            stall_n_if = 1'b0;
            stall_n_id = 1'b0;
            stall_n_ex = 1'b0;
            flush_ls   = 1'b1;
          end else if (bus.ex_mret) begin
            stall_n_if = 1'b0;
            stall_n_id = 1'b0;
            flush_ex   = 1'b1;
            mepc_d     = bus.mepc;
            state_d    = EXIT;
          end else if (bus.ex_br_taken) begin
            redirect_valid = 1'b1;
            redirect_pc    = bus.ex_br_target;
            flush_id       = 1'b1;
            flush_ex       = 1'b1;
          end else if (load_use) begin
            stall_n_if = 1'b0;
            stall_n_id = 1'b0;
            flush_ex   = 1'b1;
          end else if (bus.if_busy) begin
            stall_n_if = 1'b0;
            flush_id   = 1'b1;
          end
        end
        DRAIN: begin
          stall_n_if = 1'b0;
          stall_n_id = 1'b0;
          stall_n_ex = 1'b0;
          stall_n_ls = 1'b0;
          if (!bus.ls_busy) state_d = ENTER;
        end
        ENTER: begin
          redirect_valid = 1'b1;
          redirect_pc    = vec_q;
          flush_id       = 1'b1;
          flush_ex       = 1'b1;
          flush_ls       = 1'b1;
          in_trap_id     = 1'b1;
          trap_ack       = 1'b1;
          state_d        = RUN;
        end
        EXIT: begin
          redirect_valid = 1'b1;
          redirect_pc    = mepc_q;
          flush_id       = 1'b1;
          flush_ex       = 1'b1;
          out_trap_id    = 1'b1;
          state_d        = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      vec_q   <= '0;
      mepc_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      mepc_q  <= mepc_d;
    end
  end

  assign bus.stall_n_if     = stall_n_if;
  assign bus.stall_n_id     = stall_n_id;
  assign bus.stall_n_ex     = stall_n_ex;
  assign bus.stall_n_ls     = stall_n_ls;
  assign bus.flush_id       = flush_id;
  assign bus.flush_ex       = flush_ex;
  assign bus.flush_ls       = flush_ls;
  assign bus.in_trap_id     = in_trap_id;
  assign bus.out_trap_id    = out_trap_id;
  assign bus.trap_ack       = trap_ack;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] redirect_cnt_q;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (!stall_n_if)    stall_cnt_q    <= stall_cnt_q + 32'd1;
      if (redirect_valid) redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.redirect_cnt = redirect_cnt_q;
`else
  assign bus.stall_cnt    = '0;
  assign bus.redirect_cnt = '0;
`endif

endmodule
